// File: rtl/cc_branch_unit_if.sv
// Branch-unit bus: register-file write snoop, branch request and resolved branch result.
// The master drives writes and branches; the slave (cc_branch_unit) returns results and statistics.
interface cc_branch_unit_if #(
    parameter int DATA_W   = 16,
    parameter int NUM_CC   = 1,
    parameter int CC_IDX_W = 1,
    parameter int CNT_W    = 16
);
    logic [DATA_W-1:0]   result_in;
    logic                we_reg_in;
    logic [CC_IDX_W-1:0] wr_bank_in;
    logic                br_in;
    logic [2:0]          nzp_dec_in;
    logic [CC_IDX_W-1:0] rd_bank_in;
    logic                clr_cnt_in;
    logic                pc_ctl_0_out;
    logic                br_valid_out;
    logic [3*NUM_CC-1:0] state_out;
    logic [CNT_W-1:0]    br_cnt_out;
    logic [CNT_W-1:0]    taken_cnt_out;

    modport master (
        output result_in, we_reg_in, wr_bank_in, br_in, nzp_dec_in, rd_bank_in, clr_cnt_in,
        input  pc_ctl_0_out, br_valid_out, state_out, br_cnt_out, taken_cnt_out
    );

    modport slave (
        input  result_in, we_reg_in, wr_bank_in, br_in, nzp_dec_in, rd_bank_in, clr_cnt_in,
        output pc_ctl_0_out, br_valid_out, state_out, br_cnt_out, taken_cnt_out
    );
endinterface

// File: rtl/cc_branch_unit.sv
// Condition-code banks (N/Z/P per context), branch resolution and saturating branch statistics.
// Optional macro CC_FORWARD_EN: same-cycle write-through of flags to a branch testing the written bank.
module cc_branch_unit #(
    parameter int DATA_W   = 16,
    parameter int NUM_CC   = 1,
    parameter int CC_IDX_W = 1,
    parameter int CNT_W    = 16
) (
    input logic            clka,
    input logic            reset_in,
    cc_branch_unit_if.slave bus
);
    // Handshake: br_in qualifies nzp_dec_in/rd_bank_in in its cycle; br_valid_out qualifies
    // pc_ctl_0_out for exactly the following cycle. No back-pressure, one branch per cycle.

    typedef enum logic [2:0] {
        CC_IDLE = 3'b000,
        CC_P    = 3'b001,
        CC_Z    = 3'b010,
        CC_N    = 3'b100
    } cc_state_t;

    cc_state_t          bank_q [NUM_CC];
    cc_state_t          new_cc;
    cc_state_t          rd_cc;
    logic [NUM_CC-1:0]  bank_we;
    logic               taken;
    logic               pc_ctl_q;
    logic               br_valid_q;
    logic [CNT_W-1:0]   br_cnt_q;
    logic [CNT_W-1:0]   taken_cnt_q;

    always_comb begin
        new_cc = CC_P;
        if (bus.result_in[DATA_W-1])
            new_cc = CC_N;
        else if (bus.result_in == '0)
            new_cc = CC_Z;
    end

    // Out-of-range bank indices match no k, so such writes are dropped and such reads see IDLE.
    always_comb begin
        bank_we = '0;
        rd_cc   = CC_IDLE;
        for (int k = 0; k < NUM_CC; k++) begin
            if (bus.we_reg_in && (bus.wr_bank_in == CC_IDX_W'(k)))
                bank_we[k] = 1'b1;
            if (bus.rd_bank_in == CC_IDX_W'(k))
                rd_cc = bank_q[k];
        end
`ifdef CC_FORWARD_EN
        if ((|bank_we) && (bus.wr_bank_in == bus.rd_bank_in))
            rd_cc = new_cc;
`endif
        taken = |(bus.nzp_dec_in & rd_cc);
    end

    always_ff @(posedge clka) begin
        if (reset_in) begin
            for (int k = 0; k < NUM_CC; k++)
                bank_q[k] <= CC_IDLE;
            pc_ctl_q    <= 1'b0;
            br_valid_q  <= 1'b0;
            br_cnt_q    <= '0;
            taken_cnt_q <= '0;
        end else begin
            for (int k = 0; k < NUM_CC; k++)
                if (bank_we[k])
                    bank_q[k] <= new_cc;
            pc_ctl_q   <= bus.br_in & taken;
            br_valid_q <= bus.br_in;
            // Clear beats a same-cycle increment; counters stick at all-ones.
            if (bus.clr_cnt_in) begin
                br_cnt_q    <= '0;
                taken_cnt_q <= '0;
            end else begin
                if (bus.br_in && !(&br_cnt_q))
                    br_cnt_q <= br_cnt_q + 1'b1;
                if (bus.br_in && taken && !(&taken_cnt_q))
                    taken_cnt_q <= taken_cnt_q + 1'b1;
            end
        end
    end

    always_comb begin
        bus.state_out = '0;
        for (int k = 0; k < NUM_CC; k++)
            bus.state_out[3*k +: 3] = bank_q[k];
    end

    assign bus.pc_ctl_0_out  = pc_ctl_q;
    assign bus.br_valid_out  = br_valid_q;
    assign bus.br_cnt_out    = br_cnt_q;
    assign bus.taken_cnt_out = taken_cnt_q;
endmodule
